// File: rtl/krnl_acc_ctrl_seq.sv
// Job sequencer between the AXI-Lite control slave and the load/compute/store engines.
// Walks every input-channel group for each output-channel group; one command in flight at a time.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for ap_start, ap_idle high
// LD_IFM | IFM load command presented
// W_IFM  | waiting for IFM load done
// LD_WGT | weight load command presented
// W_WGT  | waiting for weight load done
// CMP    | compute command presented
// W_CMP  | waiting for compute done
// ST     | store command presented
// W_ST   | waiting for store done
// DONE   | ap_done held until ap_continue
module krnl_acc_ctrl_seq #(
    parameter int CNT_W          = 16,
    parameter int IFM_TILE_BYTES = 4096,
    parameter int WGT_TILE_BYTES = 1024,
    parameter int OFM_TILE_BYTES = 4096
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    input  logic        ap_start,
    input  logic        ap_continue,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic        ap_done,
    input  logic [31:0] cfg_ci,
    input  logic [31:0] cfg_co,
    input  logic [63:0] ifm_addr_base,
    input  logic [63:0] wgt_addr_base,
    input  logic [63:0] ofm_addr_base,
    output logic        ld_cmd_valid,
    input  logic        ld_cmd_ready,
    output logic        ld_cmd_sel,
    output logic [63:0] ld_cmd_addr,
    output logic [31:0] ld_cmd_len,
    input  logic        ld_done,
    output logic        cmp_cmd_valid,
    input  logic        cmp_cmd_ready,
    output logic        cmp_first,
    output logic        cmp_last,
    input  logic        cmp_done,
    output logic        st_cmd_valid,
    input  logic        st_cmd_ready,
    output logic [63:0] st_cmd_addr,
    output logic [31:0] st_cmd_len,
    input  logic        st_done
);
    typedef enum logic [3:0] {
        IDLE, LD_IFM, W_IFM, LD_WGT, W_WGT, CMP, W_CMP, ST, W_ST, DONE
    } state_t;

    localparam logic [63:0] IFM_STEP = 64'(IFM_TILE_BYTES);
    localparam logic [63:0] WGT_STEP = 64'(WGT_TILE_BYTES);
    localparam logic [63:0] OFM_STEP = 64'(OFM_TILE_BYTES);
    localparam logic [31:0] IFM_LEN  = 32'(IFM_TILE_BYTES);
    localparam logic [31:0] WGT_LEN  = 32'(WGT_TILE_BYTES);
    localparam logic [31:0] OFM_LEN  = 32'(OFM_TILE_BYTES);

    state_t           state_q;
    logic [CNT_W-1:0] ci_n_q, co_n_q, ci_idx_q, co_idx_q;
    logic [63:0]      ifm_base_q, ifm_ptr_q, wgt_ptr_q, ofm_ptr_q;
    logic             ap_idle_q, ap_ready_q, ap_done_q;
    logic             ld_valid_q, ld_sel_q, cmp_valid_q, cmp_first_q, cmp_last_q, st_valid_q;
    logic [63:0]      ld_addr_q, st_addr_q;
    logic [31:0]      ld_len_q, st_len_q;

    logic [CNT_W-1:0] cfg_ci_w, cfg_co_w;
    logic             ci_last, co_last;
    logic             unused_cfg_hi;

    assign cfg_ci_w      = cfg_ci[CNT_W-1:0];
    assign cfg_co_w      = cfg_co[CNT_W-1:0];
    assign unused_cfg_hi = ^{cfg_ci[31:CNT_W], cfg_co[31:CNT_W]};
    assign ci_last       = (ci_idx_q == ci_n_q - CNT_W'(1));
    assign co_last       = (co_idx_q == co_n_q - CNT_W'(1));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            ci_n_q      <= '0;
            co_n_q      <= '0;
            ci_idx_q    <= '0;
            co_idx_q    <= '0;
            ifm_base_q  <= '0;
            ifm_ptr_q   <= '0;
            wgt_ptr_q   <= '0;
            ofm_ptr_q   <= '0;
            ap_idle_q   <= 1'b1;
            ap_ready_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            ld_valid_q  <= 1'b0;
            ld_sel_q    <= 1'b0;
            ld_addr_q   <= '0;
            ld_len_q    <= '0;
            cmp_valid_q <= 1'b0;
            cmp_first_q <= 1'b0;
            cmp_last_q  <= 1'b0;
            st_valid_q  <= 1'b0;
            st_addr_q   <= '0;
            st_len_q    <= '0;
        end else begin
            ap_ready_q <= 1'b0;
            case (state_q)
                IDLE: if (ap_start) begin
                    ci_n_q     <= cfg_ci_w;
                    co_n_q     <= cfg_co_w;
                    ci_idx_q   <= '0;
                    co_idx_q   <= '0;
                    ifm_base_q <= ifm_addr_base;
                    ifm_ptr_q  <= ifm_addr_base;
                    wgt_ptr_q  <= wgt_addr_base;
                    ofm_ptr_q  <= ofm_addr_base;
                    ap_ready_q <= 1'b1;
                    ap_idle_q  <= 1'b0;
                    if (cfg_ci_w == '0 || cfg_co_w == '0) begin
                        state_q   <= DONE;
                        ap_done_q <= 1'b1;
                    end else begin
                        state_q    <= LD_IFM;
                        ld_valid_q <= 1'b1;
                        ld_sel_q   <= 1'b0;
                        ld_addr_q  <= ifm_addr_base;
                        ld_len_q   <= IFM_LEN;
                    end
                end
                LD_IFM, LD_WGT: if (ld_cmd_ready) begin
                    ld_valid_q <= 1'b0;
                    state_q    <= (state_q == LD_IFM) ? W_IFM : W_WGT;
                end
                W_IFM: if (ld_done) begin
                    state_q    <= LD_WGT;
                    ld_valid_q <= 1'b1;
                    ld_sel_q   <= 1'b1;
                    ld_addr_q  <= wgt_ptr_q;
                    ld_len_q   <= WGT_LEN;
                end
                W_WGT: if (ld_done) begin
                    state_q     <= CMP;
                    cmp_valid_q <= 1'b1;
                    cmp_first_q <= (ci_idx_q == '0);
                    cmp_last_q  <= ci_last;
                end
                CMP: if (cmp_cmd_ready) begin
                    cmp_valid_q <= 1'b0;
                    state_q     <= W_CMP;
                end
                W_CMP: if (cmp_done) begin
                    ifm_ptr_q <= ifm_ptr_q + IFM_STEP;
                    wgt_ptr_q <= wgt_ptr_q + WGT_STEP;
                    if (ci_last) begin
                        state_q    <= ST;
                        st_valid_q <= 1'b1;
                        st_addr_q  <= ofm_ptr_q;
                        st_len_q   <= OFM_LEN;
                    end else begin
                        ci_idx_q   <= ci_idx_q + CNT_W'(1);
                        state_q    <= LD_IFM;
                        ld_valid_q <= 1'b1;
                        ld_sel_q   <= 1'b0;
                        ld_addr_q  <= ifm_ptr_q + IFM_STEP;
                        ld_len_q   <= IFM_LEN;
                    end
                end
                ST: if (st_cmd_ready) begin
                    st_valid_q <= 1'b0;
                    state_q    <= W_ST;
                end
                // IFM tiles are re-read for every co group; weights keep advancing.
                W_ST: if (st_done) begin
                    ofm_ptr_q <= ofm_ptr_q + OFM_STEP;
                    ci_idx_q  <= '0;
                    ifm_ptr_q <= ifm_base_q;
                    if (co_last) begin
                        state_q   <= DONE;
                        ap_done_q <= 1'b1;
                    end else begin
                        co_idx_q   <= co_idx_q + CNT_W'(1);
                        state_q    <= LD_IFM;
                        ld_valid_q <= 1'b1;
                        ld_sel_q   <= 1'b0;
                        ld_addr_q  <= ifm_base_q;
                        ld_len_q   <= IFM_LEN;
                    end
                end
                DONE: if (ap_continue) begin
                    state_q   <= IDLE;
                    ap_done_q <= 1'b0;
                    ap_idle_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ap_idle       = ap_idle_q;
    assign ap_ready      = ap_ready_q;
    assign ap_done       = ap_done_q;
    assign ld_cmd_valid  = ld_valid_q;
    assign ld_cmd_sel    = ld_sel_q;
    assign ld_cmd_addr   = ld_addr_q;
    assign ld_cmd_len    = ld_len_q;
    assign cmp_cmd_valid = cmp_valid_q;
    assign cmp_first     = cmp_first_q;
    assign cmp_last      = cmp_last_q;
    assign st_cmd_valid  = st_valid_q;
    assign st_cmd_addr   = st_addr_q;
    assign st_cmd_len    = st_len_q;
endmodule

// File: tb/tb_krnl_acc_ctrl_seq.sv
// Scoreboard bench for krnl_acc_ctrl_seq: expected commands are queued per job,
// a monitor pops and compares on every command handshake.
module tb_krnl_acc_ctrl_seq;
    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        ap_start, ap_continue, ap_idle, ap_ready, ap_done;
    logic [31:0] cfg_ci, cfg_co;
    logic [63:0] ifm_addr_base, wgt_addr_base, ofm_addr_base;
    logic        ld_cmd_valid, ld_cmd_ready, ld_cmd_sel, ld_done;
    logic [63:0] ld_cmd_addr, st_cmd_addr;
    logic [31:0] ld_cmd_len, st_cmd_len;
    logic        cmp_cmd_valid, cmp_cmd_ready, cmp_first, cmp_last, cmp_done;
    logic        st_cmd_valid, st_cmd_ready, st_done;

    logic ld_rdy = 1'b1;
    logic ld_done_eng = 1'b0, cmp_done_eng = 1'b0, st_done_eng = 1'b0;
    logic ld_done_spur = 1'b0, cmp_done_spur = 1'b0;

    assign ld_cmd_ready  = ld_rdy;
    assign cmp_cmd_ready = 1'b1;
    assign st_cmd_ready  = 1'b1;
    assign ld_done  = ld_done_eng | ld_done_spur;
    assign cmp_done = cmp_done_eng | cmp_done_spur;
    assign st_done  = st_done_eng;

    always #5 ACLK = ~ACLK;

    krnl_acc_ctrl_seq dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
        .cfg_ci(cfg_ci), .cfg_co(cfg_co),
        .ifm_addr_base(ifm_addr_base), .wgt_addr_base(wgt_addr_base), .ofm_addr_base(ofm_addr_base),
        .ld_cmd_valid(ld_cmd_valid), .ld_cmd_ready(ld_cmd_ready), .ld_cmd_sel(ld_cmd_sel),
        .ld_cmd_addr(ld_cmd_addr), .ld_cmd_len(ld_cmd_len), .ld_done(ld_done),
        .cmp_cmd_valid(cmp_cmd_valid), .cmp_cmd_ready(cmp_cmd_ready),
        .cmp_first(cmp_first), .cmp_last(cmp_last), .cmp_done(cmp_done),
        .st_cmd_valid(st_cmd_valid), .st_cmd_ready(st_cmd_ready),
        .st_cmd_addr(st_cmd_addr), .st_cmd_len(st_cmd_len), .st_done(st_done)
    );

    typedef struct packed {
        logic [1:0]  kind;   // 0 IFM, 1 WGT, 2 CMP, 3 ST
        logic [63:0] addr;
        logic [31:0] len;
        logic        first;
        logic        last;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    function automatic void observe(input cmd_t got);
        cmd_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_cmd: got 0x%0h expected none", got);
        end else begin
            e = exp_q.pop_front();
            check("cmd", 128'(got), 128'(e));
        end
    endfunction

    // Monitor: a handshake seen at a negedge completes on the following posedge.
    initial forever begin
        @(negedge ACLK);
        if (ld_cmd_valid && ld_cmd_ready)
            observe('{kind: {1'b0, ld_cmd_sel}, addr: ld_cmd_addr, len: ld_cmd_len, first: 1'b0, last: 1'b0});
        if (cmp_cmd_valid && cmp_cmd_ready)
            observe('{kind: 2'd2, addr: 64'd0, len: 32'd0, first: cmp_first, last: cmp_last});
        if (st_cmd_valid && st_cmd_ready)
            observe('{kind: 2'd3, addr: st_cmd_addr, len: st_cmd_len, first: 1'b0, last: 1'b0});
    end

    // Engine models: done pulse sampled on the third rising edge after the accepting edge.
    initial forever begin
        @(negedge ACLK);
        if (ld_cmd_valid && ld_cmd_ready) begin
            repeat (3) @(posedge ACLK);
            #1 ld_done_eng = 1'b1;
            @(posedge ACLK);
            #1 ld_done_eng = 1'b0;
        end
    end
    initial forever begin
        @(negedge ACLK);
        if (cmp_cmd_valid && cmp_cmd_ready) begin
            repeat (3) @(posedge ACLK);
            #1 cmp_done_eng = 1'b1;
            @(posedge ACLK);
            #1 cmp_done_eng = 1'b0;
        end
    end
    initial forever begin
        @(negedge ACLK);
        if (st_cmd_valid && st_cmd_ready) begin
            repeat (3) @(posedge ACLK);
            #1 st_done_eng = 1'b1;
            @(posedge ACLK);
            #1 st_done_eng = 1'b0;
        end
    end

    task automatic push_job(input int ci, input int co, input logic [63:0] ib, input logic [63:0] wb,
                            input logic [63:0] ob);
        for (int c = 0; c < co; c++) begin
            for (int i = 0; i < ci; i++) begin
                exp_q.push_back('{kind: 2'd0, addr: ib + 64'(i) * 64'd4096, len: 32'd4096, first: 1'b0, last: 1'b0});
                exp_q.push_back('{kind: 2'd1, addr: wb + 64'(c * ci + i) * 64'd1024, len: 32'd1024,
                                  first: 1'b0, last: 1'b0});
                exp_q.push_back('{kind: 2'd2, addr: 64'd0, len: 32'd0, first: (i == 0), last: (i == ci - 1)});
            end
            exp_q.push_back('{kind: 2'd3, addr: ob + 64'(c) * 64'd4096, len: 32'd4096, first: 1'b0, last: 1'b0});
        end
    endtask

    task automatic set_cfg(input int ci, input int co, input logic [63:0] ib, input logic [63:0] wb,
                           input logic [63:0] ob);
        cfg_ci = 32'(ci);
        cfg_co = 32'(co);
        ifm_addr_base = ib;
        wgt_addr_base = wb;
        ofm_addr_base = ob;
    endtask

    task automatic start_job(input int ci, input int co, input logic [63:0] ib, input logic [63:0] wb,
                             input logic [63:0] ob);
        bit seen = 0;
        @(posedge ACLK);
        #1 set_cfg(ci, co, ib, wb, ob);
        ap_start = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            seen = ap_ready;
        end
        check("ap_ready_seen", 128'(seen), 128'(1));
        ap_start = 1'b0;
        @(negedge ACLK);
        check("ap_ready_one_cycle", 128'(ap_ready), 128'(0));
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge ACLK);
            seen = ap_done;
        end
        check("ap_done_seen", 128'(seen), 128'(1));
        check("idle_low_in_done", 128'(ap_idle), 128'(0));
        check("all_cmds_issued", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic do_continue();
        @(posedge ACLK);
        #1 ap_continue = 1'b1;
        @(posedge ACLK);
        #1 ap_continue = 1'b0;
        @(negedge ACLK);
        check("after_continue_done_idle", 128'({ap_done, ap_idle}), 128'(2'b01));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit seen;
        ARESETn = 1'b0;
        ap_start = 1'b0;
        ap_continue = 1'b0;
        set_cfg(0, 0, 64'd0, 64'd0, 64'd0);
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        check("reset_outputs",
              128'({ap_idle, ap_ready, ap_done, ld_cmd_valid, ld_cmd_sel, ld_cmd_addr, ld_cmd_len,
                    cmp_cmd_valid, cmp_first, cmp_last, st_cmd_valid}),
              128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("reset_st_payload", 128'({st_cmd_addr, st_cmd_len}), 128'(0));

        // ci=2, co=1
        push_job(2, 1, 64'h1000, 64'h8000, 64'h10000);
        start_job(2, 1, 64'h1000, 64'h8000, 64'h10000);
        wait_done();
        do_continue();

        // ci=1, co=3: weights advance across co, IFM restarts at base
        push_job(1, 3, 64'h1000, 64'h8000, 64'h10000);
        start_job(1, 3, 64'h1000, 64'h8000, 64'h10000);
        wait_done();
        do_continue();

        // cfg_ci=0: straight to DONE, no commands
        start_job(0, 5, 64'h1000, 64'h8000, 64'h10000);
        wait_done();
        do_continue();

        // pointer wrap modulo 2^64
        push_job(2, 1, 64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_FC00, 64'hFFFF_FFFF_FFFF_F000);
        start_job(2, 1, 64'hFFFF_FFFF_FFFF_F000, 64'hFFFF_FFFF_FFFF_FC00, 64'hFFFF_FFFF_FFFF_F000);
        wait_done();
        do_continue();

        // load engine stalls 10 cycles; spurious done pulses ignored
        ld_rdy = 1'b0;
        push_job(1, 1, 64'h1000, 64'h8000, 64'h10000);
        start_job(1, 1, 64'h1000, 64'h8000, 64'h10000);
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            check("ld_stall_stable", 128'({ld_cmd_valid, ld_cmd_sel, ld_cmd_addr, ld_cmd_len}),
                  128'({1'b1, 1'b0, 64'h1000, 32'd4096}));
            if (i == 4) ld_done_spur = 1'b1;
            if (i == 5) ld_done_spur = 1'b0;
        end
        @(posedge ACLK);
        #1 ld_rdy = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK);
        #1 cmp_done_spur = 1'b1;
        @(posedge ACLK);
        #1 cmp_done_spur = 1'b0;
        wait_done();

        // continue withheld 20 cycles, next start pending in DONE
        push_job(1, 1, 64'h4000, 64'h9000, 64'h20000);
        set_cfg(1, 1, 64'h4000, 64'h9000, 64'h20000);
        ap_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            check("done_held", 128'({ap_done, ap_idle, ap_ready}), 128'(3'b100));
        end
        @(posedge ACLK);
        #1 ap_continue = 1'b1;
        @(posedge ACLK);
        #1 ap_continue = 1'b0;
        @(negedge ACLK);
        check("b2b_first_idle", 128'({ap_done, ap_idle, ap_ready}), 128'(3'b010));
        @(negedge ACLK);
        check("b2b_accept", 128'({ap_ready, ap_idle}), 128'(2'b10));
        ap_start = 1'b0;
        wait_done();
        do_continue();

        // reset while in W_CMP
        push_job(2, 1, 64'h1000, 64'h8000, 64'h10000);
        start_job(2, 1, 64'h1000, 64'h8000, 64'h10000);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge ACLK);
            seen = cmp_cmd_valid && cmp_cmd_ready;
        end
        check("cmp_handshake_seen", 128'(seen), 128'(1));
        @(posedge ACLK);
        #1 ARESETn = 1'b0;
        exp_q.delete();
        #1;
        check("mid_job_reset",
              128'({ap_idle, ap_ready, ap_done, ld_cmd_valid, ld_cmd_sel, ld_cmd_addr, ld_cmd_len,
                    cmp_cmd_valid, cmp_first, cmp_last, st_cmd_valid}),
              128'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0}));
        check("mid_job_reset_st", 128'({st_cmd_addr, st_cmd_len}), 128'(0));
        repeat (10) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        push_job(1, 1, 64'h1000, 64'h8000, 64'h10000);
        start_job(1, 1, 64'h1000, 64'h8000, 64'h10000);
        wait_done();
        do_continue();

        repeat (5) @(negedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/krnl_acc_ctrl_seq.md
Name: krnl_acc_ctrl_seq

Overview:
Job sequencer that sits directly downstream of the AXI-Lite control slave. It consumes ap_start/ap_continue, cfg_ci, cfg_co and the three DDR base addresses, and answers with ap_idle/ap_ready/ap_done under ap_ctrl_chain semantics. For each output-channel group it walks all input-channel groups: it issues IFM and weight load commands and a compute command per input group, then one store command. Every command uses a valid/ready handshake followed by a done pulse from the engine.

Parameters:
CNT_W, 16, width of the ci/co loop counters; only cfg_ci[CNT_W-1:0] and cfg_co[CNT_W-1:0] are used.
IFM_TILE_BYTES, 4096, byte stride per IFM tile and length of an IFM load.
WGT_TILE_BYTES, 1024, byte stride per weight tile and length of a weight load.
OFM_TILE_BYTES, 4096, byte stride per OFM tile and length of a store.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
ap_start  in  1  start request, held high until ap_ready
ap_continue  in  1  one-cycle acknowledge of ap_done
ap_idle  out  1  sequencer in IDLE
ap_ready  out  1  one-cycle pulse: job accepted, config latched
ap_done  out  1  level: job finished, held until ap_continue
cfg_ci  in  32  number of input-channel groups
cfg_co  in  32  number of output-channel groups
ifm_addr_base  in  64  IFM base address
wgt_addr_base  in  64  weight base address
ofm_addr_base  in  64  OFM base address
ld_cmd_valid  out  1  load command valid
ld_cmd_ready  in  1  load engine accepts command
ld_cmd_sel  out  1  0 = IFM, 1 = weight
ld_cmd_addr  out  64  load start address
ld_cmd_len  out  32  load length in bytes
ld_done  in  1  one-cycle pulse: load complete
cmp_cmd_valid  out  1  compute command valid
cmp_cmd_ready  in  1  PE array accepts command
cmp_first  out  1  first ci of this co (clear accumulators)
cmp_last  out  1  last ci of this co
cmp_done  in  1  one-cycle pulse: compute complete
st_cmd_valid  out  1  store command valid
st_cmd_ready  in  1  store engine accepts command
st_cmd_addr  out  64  store start address
st_cmd_len  out  32  store length in bytes
st_done  in  1  one-cycle pulse: store complete

Behaviour:
- Reset (async assert, sync release): state IDLE; all counters and pointers 0; ap_idle=1; ap_ready=0; ap_done=0; all *_valid=0; addr/len/flag outputs=0.
- States: IDLE, LD_IFM, W_IFM, LD_WGT, W_WGT, CMP, W_CMP, ST, W_ST, DONE.
- IDLE:
  - If ap_start=1, latch ci_n=cfg_ci[CNT_W-1:0], co_n=cfg_co[CNT_W-1:0] and all three bases.
  - Set ifm_ptr=ifm_base, wgt_ptr=wgt_base, ofm_ptr=ofm_base, ci_idx=0, co_idx=0.
  - Next state is LD_IFM, or DONE if ci_n==0 or co_n==0 (no commands are issued).
  - ap_ready is registered: high exactly one cycle, the cycle after acceptance.
- LD_IFM: ld_cmd_valid=1, sel=0, addr=ifm_ptr, len=IFM_TILE_BYTES. On ready: go to W_IFM. On ld_done: go to LD_WGT.
- LD_WGT: same, with sel=1, addr=wgt_ptr, len=WGT_TILE_BYTES. On ld_done: go to CMP.
- CMP: cmp_cmd_valid=1, cmp_first=(ci_idx==0), cmp_last=(ci_idx==ci_n-1). On ready: go to W_CMP.
- W_CMP, on cmp_done:
  - ifm_ptr += IFM_TILE_BYTES; wgt_ptr += WGT_TILE_BYTES.
  - If ci_idx==ci_n-1, go to ST. Otherwise ci_idx++ and go to LD_IFM.
- ST: st_cmd_valid=1, addr=ofm_ptr, len=OFM_TILE_BYTES. On ready: go to W_ST.
- W_ST, on st_done:
  - ofm_ptr += OFM_TILE_BYTES; ci_idx=0; ifm_ptr=latched ifm_base.
  - If co_idx==co_n-1, go to DONE. Otherwise co_idx++ and go to LD_IFM.
- DONE: ap_done=1. When ap_continue=1, go to IDLE; ap_done drops the next cycle.
- Valid/payload rules: payloads are stable while valid=1 and ready=0. valid drops the cycle after the handshake. Issue order is always IFM, WGT, CMP per ci, then ST.
- Address arithmetic: pointers are 64-bit unsigned and wrap modulo 2^64; the weight pointer runs continuously across co groups.
- Ignored events:
  - Done pulses outside their matching W_* state.
  - ap_start outside IDLE; it stays pending and is accepted on return to IDLE.
  - ap_continue outside DONE.
- ap_idle=1 only in IDLE, so ap_idle=0 while in DONE.
- Reset mid-job: immediate return to IDLE with reset values; a pending engine command is dropped.
- Back-to-back jobs: if ap_start is high during the DONE→IDLE cycle, the next job is accepted in that first IDLE cycle.

Test Plan:
- ci=2, co=1, bases 0x1000/0x8000/0x10000, engines ready=1, done 3 cycles after ready:
  - ld IFM 0x1000, ld WGT 0x8000, cmp first=1/last=0;
  - ld IFM 0x2000, ld WGT 0x8400, cmp first=0/last=1;
  - st 0x10000; then ap_done=1.
- ci=1, co=3 → store addresses 0x10000, 0x11000, 0x12000; every cmp has first=last=1; weight addresses 0x8000, 0x8400, 0x8800.
- cfg_ci=0, co=5 → ap_ready pulse, then DONE with no *_valid ever high; ap_continue → idle.
- ld_cmd_ready held 0 for 10 cycles → ld_cmd_valid, addr and len constant for all 10 cycles; exactly one command issued; spurious cmp_done in W_IFM ignored.
- ap_continue withheld 20 cycles → ap_done stays 1 and ap_idle stays 0; ap_start high during DONE is accepted only after continue.
- ARESETn low while in W_CMP → all outputs at reset values the same cycle; new job after release restarts at ifm_base.
